// File: rtl/fetch_pkg.sv
// ============================================================================
// fetch_pkg : shared types and constants for the instruction-fetch front end
// Rev 1.0
// ============================================================================
`default_nettype none

package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  localparam int INSTR_BYTES = 4;

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ============================================================================
// fetch_fifo : synchronous FIFO with push/pop/flush and occupancy count
// Rev 1.0
// ============================================================================
`default_nettype none

module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           push,
  input  logic [WIDTH-1:0]               push_data,
  input  logic                           pop,
  input  logic                           flush,
  output logic [WIDTH-1:0]               head_data,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           empty
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;
  logic             w_full;
  logic             w_push;
  logic             w_pop;

  assign w_full    = (r_count == CW'(DEPTH));
  assign empty     = (r_count == '0);
  assign w_push    = push && !w_full;
  assign w_pop     = pop && !empty;
  assign head_data = r_mem[r_rd_ptr];
  assign count     = r_count;

  // DEPTH is a power of two, so pointers wrap naturally
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= push_data;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// fetch_unit : decoupled request/response instruction fetch with redirect drain
// Rev 1.0
// ============================================================================
`default_nettype none

module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 64,
  parameter int                INSTR_W  = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_data,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               busy_drain
);

  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW:0] c_depth = (CW+1)'(DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] data;
  } fetch_entry_t;

  fetch_state_t      r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [CW-1:0]     r_drop_cnt, w_drop_cnt_nxt;
  logic [CW-1:0]     w_fifo_count;
  logic [CW-1:0]     w_outstanding;
  logic [CW-1:0]     w_outstanding_after;
  logic [CW:0]       w_credit_used;
  logic              w_fifo_empty;
  logic              w_pcq_empty;
  logic [ADDR_W-1:0] w_pcq_head;
  fetch_entry_t      w_head, w_push_entry;
  logic              w_fire, w_rsp_accept, w_pop;

  assign w_credit_used       = {1'b0, w_fifo_count} + {1'b0, w_outstanding};
  assign w_fire              = imem_req_valid && imem_req_ready;
  assign w_rsp_accept        = imem_rsp_valid && (r_state == RUN) && !redirect_valid && !w_pcq_empty;
  assign w_pop               = instr_valid && instr_ready;
  // A response landing in the redirect cycle is dropped immediately, not drained
  assign w_outstanding_after = (imem_rsp_valid && !w_pcq_empty) ? w_outstanding - CW'(1) : w_outstanding;
  assign w_push_entry        = '{pc: w_pcq_head, data: imem_rsp_data};

  assign imem_req_addr = r_pc;
  assign instr_valid   = !w_fifo_empty;
  assign instr_data    = instr_valid ? w_head.data : '0;
  assign instr_pc      = instr_valid ? w_head.pc   : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= BOOT;
      r_pc       <= RESET_PC;
      r_drop_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_drop_cnt <= w_drop_cnt_nxt;
      if (redirect_valid)  r_pc <= redirect_pc;
      else if (w_fire)     r_pc <= r_pc + ADDR_W'(INSTR_BYTES);
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_drop_cnt_nxt = r_drop_cnt;
    imem_req_valid = 1'b0;
    busy_drain     = 1'b0;
    case (r_state)
      BOOT: w_state_nxt = RUN;
      RUN: begin
        imem_req_valid = !redirect_valid && (w_credit_used < c_depth);
        if (redirect_valid && (w_outstanding_after != '0)) begin
          w_state_nxt    = DRAIN;
          w_drop_cnt_nxt = w_outstanding_after;
        end
      end
      DRAIN: begin
        busy_drain = 1'b1;
        if (imem_rsp_valid) begin
          w_drop_cnt_nxt = r_drop_cnt - CW'(1);
          if (r_drop_cnt == CW'(1)) w_state_nxt = RUN;
        end
      end
      default: w_state_nxt = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset && imem_rsp_valid && (r_state != DRAIN)) assert (!w_pcq_empty);
  end

  fetch_fifo #(.WIDTH(ADDR_W), .DEPTH(DEPTH)) u_pc_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (w_fire),
    .push_data (r_pc),
    .pop       (w_rsp_accept),
    .flush     (redirect_valid),
    .head_data (w_pcq_head),
    .count     (w_outstanding),
    .empty     (w_pcq_empty)
  );

  fetch_fifo #(.WIDTH(ADDR_W + INSTR_W), .DEPTH(DEPTH)) u_instr_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (w_rsp_accept),
    .push_data (w_push_entry),
    .pop       (w_pop),
    .flush     (redirect_valid),
    .head_data (w_head),
    .count     (w_fifo_count),
    .empty     (w_fifo_empty)
  );

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// tb_fetch_unit : randomized bench for fetch_unit with a transaction-level model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_fetch_unit;

  localparam int          ADDR_W   = 64;
  localparam int          INSTR_W  = 32;
  localparam int          DEPTH    = 4;
  localparam logic [63:0] RESET_PC = 64'h0;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req_valid, imem_req_ready = 1'b0;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        instr_valid, instr_ready = 1'b0;
  logic [31:0] instr_data;
  logic [63:0] instr_pc;
  logic        busy_drain;

  fetch_unit #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_data(instr_data),
    .instr_pc(instr_pc), .busy_drain(busy_drain)
  );

  always #5 clk = ~clk;

  typedef struct { logic [63:0] pc; logic [31:0] data; int due; bit stale; } mem_req_t;
  typedef struct { logic [63:0] pc; logic [31:0] data; } instr_t;

  mem_req_t    pend[$];      // memory-side in-flight requests, oldest first
  instr_t      exp_fifo[$];  // instructions decode should see, in order
  logic [63:0] fired[$];
  logic [63:0] popped[$];
  logic [63:0] exp_pc;
  int cyc = 0, rel_cyc = 0, passed = 0, total = 0;
  int lat_min = 1, lat_max = 1, ready_pct = 100;
  int busy_cycles = 0, first_valid_cyc = -1;
  bit booting = 1'b0;

  function automatic logic [31:0] mem_word(logic [63:0] a);
    return (a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ 32'h13579BDF;
  endfunction

  function automatic bit any_stale();
    foreach (pend[i]) if (pend[i].stale) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int live_cnt();
    int n = 0;
    foreach (pend[i]) if (!pend[i].stale) n++;
    return n;
  endfunction

  // One clock: memory drives its response, outputs are checked at negedge, model advances
  task automatic cycle();
    bit rsp, exp_rv, fire, pop;
    mem_req_t e;
    imem_req_ready = ($urandom_range(99) < ready_pct);
    rsp = (pend.size() > 0) && (pend[0].due <= cyc);
    imem_rsp_valid = rsp;
    imem_rsp_data  = '0;
    if (rsp) imem_rsp_data = pend[0].data;
    @(negedge clk);
    exp_rv = !booting && !redirect_valid && !any_stale() && ((exp_fifo.size() + live_cnt()) < DEPTH);
    total++;
    if (imem_req_valid !== exp_rv) $display("FAIL req_valid cyc=%0d got %b exp %b", cyc, imem_req_valid, exp_rv);
    else passed++;
    if (exp_rv) begin
      total++;
      if (imem_req_addr !== exp_pc) $display("FAIL req_addr cyc=%0d got %h exp %h", cyc, imem_req_addr, exp_pc);
      else passed++;
    end
    total++;
    if (instr_valid !== (exp_fifo.size() > 0))
      $display("FAIL instr_valid cyc=%0d got %b exp %b", cyc, instr_valid, exp_fifo.size() > 0);
    else passed++;
    if (exp_fifo.size() > 0) begin
      total++;
      if (instr_pc !== exp_fifo[0].pc || instr_data !== exp_fifo[0].data)
        $display("FAIL instr_head cyc=%0d got pc=%h data=%h exp pc=%h data=%h",
                 cyc, instr_pc, instr_data, exp_fifo[0].pc, exp_fifo[0].data);
      else passed++;
    end
    total++;
    if (busy_drain !== any_stale()) $display("FAIL busy_drain cyc=%0d got %b exp %b", cyc, busy_drain, any_stale());
    else passed++;

    if (instr_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (busy_drain === 1'b1) busy_cycles++;
    fire = (imem_req_valid === 1'b1) && imem_req_ready;
    pop  = (instr_valid === 1'b1) && instr_ready;
    if (pop) begin
      popped.push_back(instr_pc);
      if (exp_fifo.size() > 0) void'(exp_fifo.pop_front());
    end
    if (rsp) begin
      e = pend.pop_front();
      if (!e.stale && !redirect_valid && !booting) exp_fifo.push_back('{pc: e.pc, data: e.data});
    end
    if (redirect_valid) begin
      exp_fifo.delete();
      foreach (pend[i]) pend[i].stale = 1'b1;
    end
    if (fire) begin
      fired.push_back(imem_req_addr);
      pend.push_back('{pc: exp_pc, data: mem_word(imem_req_addr),
                       due: cyc + int'($urandom_range(lat_max, lat_min)), stale: redirect_valid});
    end
    if (redirect_valid) exp_pc = redirect_pc;
    else if (fire)      exp_pc = exp_pc + 64'd4;
    @(posedge clk);
    #1;
    cyc++;
    booting = 1'b0;
  endtask

  task automatic do_reset();
    redirect_valid = 1'b0;
    instr_ready    = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_req_ready = 1'b0;
    reset = 1'b0;
    #1;
    total++;
    if ({imem_req_valid, instr_valid, instr_data, instr_pc, busy_drain} !== '0)
      $display("FAIL reset_outputs got rv=%b iv=%b data=%h pc=%h busy=%b exp all 0",
               imem_req_valid, instr_valid, instr_data, instr_pc, busy_drain);
    else passed++;
    pend.delete(); exp_fifo.delete(); fired.delete(); popped.delete();
    @(posedge clk);
    #1;
    cyc++;
    total++;
    if ({imem_req_valid, instr_valid, busy_drain} !== 3'b000)
      $display("FAIL reset_hold got rv=%b iv=%b busy=%b exp 000", imem_req_valid, instr_valid, busy_drain);
    else passed++;
    reset = 1'b1;
    booting = 1'b1;
    exp_pc = RESET_PC;
    rel_cyc = cyc;
    first_valid_cyc = -1;
    busy_cycles = 0;
  endtask

  task automatic test_reset();
    do_reset();
    instr_ready = 1'b1;
    cycle();
  endtask

  task automatic test_startup();
    do_reset();
    lat_min = 1; lat_max = 1; ready_pct = 100; instr_ready = 1'b1;
    repeat (12) cycle();
    total++;
    if (first_valid_cyc - rel_cyc !== 3) $display("FAIL startup_latency got %0d exp 3", first_valid_cyc - rel_cyc);
    else passed++;
    total++;
    if (popped.size() !== 9) $display("FAIL startup_rate got %0d exp 9", popped.size());
    else passed++;
    for (int k = 0; k < popped.size(); k++) begin
      total++;
      if (popped[k] !== 64'(4 * k)) $display("FAIL startup_pc[%0d] got %h exp %h", k, popped[k], 64'(4 * k));
      else passed++;
    end
  endtask

  task automatic test_stall();
    do_reset();
    lat_min = 1; lat_max = 1; ready_pct = 100; instr_ready = 1'b0;
    repeat (10) cycle();
    total++;
    if (fired.size() !== DEPTH) $display("FAIL stall_requests got %0d exp %0d", fired.size(), DEPTH);
    else passed++;
    instr_ready = 1'b1;
    repeat (6) cycle();
    for (int k = 0; k < 4; k++) begin
      total++;
      if (popped.size() <= k) $display("FAIL stall_order[%0d] got none exp %h", k, 64'(4 * k));
      else if (popped[k] !== 64'(4 * k)) $display("FAIL stall_order[%0d] got %h exp %h", k, popped[k], 64'(4 * k));
      else passed++;
    end
  endtask

  // Boot, two requests with 3-cycle latency, then redirect before any response returns
  task automatic setup_drain();
    do_reset();
    lat_min = 3; lat_max = 3; ready_pct = 100; instr_ready = 1'b1;
    repeat (3) cycle();
    ready_pct = 0;
    redirect_valid = 1'b1;
    redirect_pc = 64'h100;
    cycle();
    redirect_valid = 1'b0;
    ready_pct = 100;
  endtask

  task automatic test_redirect_drain();
    int n0;
    setup_drain();
    n0 = fired.size();
    busy_cycles = 0;
    repeat (10) cycle();
    total++;
    if (busy_cycles !== 2) $display("FAIL drain_cycles got %0d exp 2", busy_cycles);
    else passed++;
    total++;
    if (fired.size() <= n0) $display("FAIL drain_next_req got none exp 100");
    else if (fired[n0] !== 64'h100) $display("FAIL drain_next_req got %h exp 100", fired[n0]);
    else passed++;
    total++;
    if (popped.size() == 0) $display("FAIL drain_first_instr got none exp 100");
    else if (popped[0] !== 64'h100) $display("FAIL drain_first_instr got %h exp 100", popped[0]);
    else passed++;
  endtask

  task automatic test_redirect_pop();
    int n_pop, exp_drop;
    bit rsp_will;
    logic [63:0] head_pc;
    do_reset();
    lat_min = 2; lat_max = 2; ready_pct = 100; instr_ready = 1'b1;
    repeat (8) cycle();
    rsp_will = (pend.size() > 0) && (pend[0].due <= cyc);
    exp_drop = live_cnt() - int'(rsp_will);
    head_pc  = (exp_fifo.size() > 0) ? exp_fifo[0].pc : 64'hX;
    total++;
    if (instr_valid !== 1'b1 || !rsp_will) $display("FAIL rp_setup got iv=%b rsp=%b exp 1 1", instr_valid, rsp_will);
    else passed++;
    n_pop = popped.size();
    redirect_valid = 1'b1;
    redirect_pc = 64'h2000;
    cycle();
    redirect_valid = 1'b0;
    busy_cycles = 0;
    repeat (12) cycle();
    total++;
    if (busy_cycles !== exp_drop) $display("FAIL rp_drop got %0d exp %0d", busy_cycles, exp_drop);
    else passed++;
    total++;
    if (popped.size() < n_pop + 2) $display("FAIL rp_pops got %0d exp >=%0d", popped.size(), n_pop + 2);
    else if (popped[n_pop] !== head_pc || popped[n_pop+1] !== 64'h2000)
      $display("FAIL rp_pops got %h,%h exp %h,2000", popped[n_pop], popped[n_pop+1], head_pc);
    else passed++;
  endtask

  task automatic test_wrap();
    int n, n_pop;
    do_reset();
    lat_min = 1; lat_max = 1; ready_pct = 100; instr_ready = 1'b1;
    repeat (4) cycle();
    redirect_valid = 1'b1;
    redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    cycle();
    redirect_valid = 1'b0;
    n = fired.size();
    n_pop = popped.size();
    repeat (8) cycle();
    total++;
    if (fired.size() < n + 2) $display("FAIL wrap_req got %0d reqs exp >=2", fired.size() - n);
    else if (fired[n] !== 64'hFFFF_FFFF_FFFF_FFFC || fired[n+1] !== 64'h0)
      $display("FAIL wrap_req got %h,%h exp fffffffffffffffc,0", fired[n], fired[n+1]);
    else passed++;
    total++;
    if (popped.size() < n_pop + 2) $display("FAIL wrap_instr got %0d pops exp >=2", popped.size() - n_pop);
    else if (popped[n_pop] !== 64'hFFFF_FFFF_FFFF_FFFC || popped[n_pop+1] !== 64'h0)
      $display("FAIL wrap_instr got %h,%h exp fffffffffffffffc,0", popped[n_pop], popped[n_pop+1]);
    else passed++;
  endtask

  task automatic test_reset_drain();
    setup_drain();
    total++;
    if (busy_drain !== 1'b1) $display("FAIL rd_in_drain got %b exp 1", busy_drain);
    else passed++;
    do_reset();
    lat_min = 1; lat_max = 1; ready_pct = 100; instr_ready = 1'b1;
    repeat (6) cycle();
    total++;
    if (fired.size() == 0) $display("FAIL rd_first_req got none exp %h", RESET_PC);
    else if (fired[0] !== RESET_PC) $display("FAIL rd_first_req got %h exp %h", fired[0], RESET_PC);
    else passed++;
    total++;
    if (popped.size() == 0) $display("FAIL rd_first_instr got none exp %h", RESET_PC);
    else if (popped[0] !== RESET_PC) $display("FAIL rd_first_instr got %h exp %h", popped[0], RESET_PC);
    else passed++;
  endtask

  task automatic test_random();
    do_reset();
    lat_min = 1; lat_max = 4; ready_pct = 70;
    for (int k = 0; k < 800; k++) begin
      instr_ready    = ($urandom_range(99) < 60);
      redirect_valid = ($urandom_range(99) < 6);
      if ($urandom_range(3) == 0) redirect_pc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(3) * 4);
      else                        redirect_pc = {$urandom(), $urandom()} & ~64'h3;
      cycle();
    end
    redirect_valid = 1'b0;
    instr_ready = 1'b1;
    repeat (20) cycle();
  endtask

  initial begin
    #400000;
    $display("FAIL timeout at cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_startup();
    test_stall();
    test_redirect_drain();
    test_redirect_pop();
    test_wrap();
    test_reset_drain();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Parametrised, decoupled instruction-fetch front end for the next-generation 64-bit core. It replaces the single-cycle PC register and next-PC adder with a request/response fetch engine. It tolerates multi-cycle instruction memory and buffers fetched instructions in a small FIFO toward decode. It accepts branch redirects from execute, flushes wrong-path work and discards stale in-flight responses.

Parameters:
ADDR_W, 64, PC/address width in bits
INSTR_W, 32, instruction width in bits
DEPTH, 4, instruction FIFO entries; also the maximum number of outstanding memory requests (power of 2, >=2)
RESET_PC, 0, PC loaded at reset

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  ADDR_W  byte address of requested instruction
imem_rsp_valid  in  1  response valid; responses return in request order, latency >=1 cycle
imem_rsp_data  in  INSTR_W  instruction word
redirect_valid  in  1  taken branch / PC override from execute
redirect_pc  in  ADDR_W  new fetch PC
instr_valid  out  1  FIFO head valid to decode
instr_ready  in  1  decode accepts head
instr_data  out  INSTR_W  head instruction
instr_pc  out  ADDR_W  PC of head instruction
busy_drain  out  1  high while discarding stale responses

Behaviour:
- Reset (reset==0, async):
  - pc=RESET_PC; FIFO empty with storage zeroed; outstanding=0; drop_cnt=0; state=BOOT.
  - Outputs: imem_req_valid=0, instr_valid=0, instr_data=0, instr_pc=0, busy_drain=0.
- State machine BOOT/RUN/DRAIN:
  - BOOT: one cycle after reset release, no request, then RUN.
  - RUN: imem_req_valid=1 iff (fifo_count+outstanding)<DEPTH and redirect_valid==0.
  - RUN, redirect with stale responses: when redirect_valid==1 and outstanding_after_this_cycle>0, go to DRAIN with drop_cnt=that count.
  - RUN, redirect with nothing in flight: stay in RUN.
  - DRAIN: imem_req_valid=0 and busy_drain=1. Each imem_rsp_valid decrements drop_cnt and its data is discarded. When drop_cnt reaches 0, go to RUN.
- Request and PC:
  - imem_req_addr=pc.
  - A request fires on valid&&ready; on fire, pc+=4 (wraps modulo 2^ADDR_W) and outstanding++.
  - valid/addr hold stable until fire, except a redirect may withdraw or change them.
- Responses:
  - In RUN, a response pushes {data, pc_of_request} into the FIFO and decrements outstanding.
  - Request PCs are kept in a DEPTH-entry PC queue alongside the requests.
  - Pushed entries become visible on instr_valid the next cycle; there is no bypass.
- Output:
  - instr_valid = !fifo_empty; instr_data/instr_pc driven combinationally from the FIFO head.
  - Pop on instr_valid&&instr_ready.
- Redirect:
  - pc <= redirect_pc.
  - FIFO and PC queue flushed at the edge.
  - A pop in the same cycle completes normally; all other entries are discarded.
  - A response arriving in the redirect cycle is treated as stale and dropped. It is not counted in drop_cnt.
  - Redirect during DRAIN updates pc only; drop_cnt is unchanged.
  - Back-to-back redirects: the last one wins.
- Credit rule guarantees no FIFO overflow:
  - fifo_count+outstanding <= DEPTH at all times.
  - A response with outstanding==0 is a protocol error (assertion); it is ignored in RTL.
- Simultaneous push and pop when full: legal only if a credit was held, which is impossible. Simultaneous push and pop on a non-full FIFO keeps the count unchanged.
- Counter widths: fifo_count and outstanding are $clog2(DEPTH+1) bits.

Decomposition:
- fetch_pkg:
  - fetch_state_t enum {BOOT, RUN, DRAIN}
  - localparam INSTR_BYTES=4
  - fetch_entry_t struct {pc, data}, parametrised by ADDR_W/INSTR_W in the user module
- Sub-module fetch_fifo:
  - synchronous FIFO, DEPTH entries, push/pop/flush, count output, async active-low reset
  - instantiated twice: instruction FIFO and in-flight PC queue

Test Plan:
1. Reset release, imem ready always, 1-cycle latency, decode ready -> requests at 0x0,0x4,0x8,...; first instr_valid 3 cycles after reset rises with instr_pc=0x0; steady 1 instr/cycle.
2. Decode instr_ready=0 for 10 cycles, DEPTH=4 -> exactly 4 requests issued; imem_req_valid low thereafter; FIFO holds PCs 0x0..0xC in order after ready returns.
3. Latency 3 cycles, 2 outstanding, redirect_pc=0x100 -> FIFO empty next cycle; busy_drain=1 until 2 stale responses discarded; next request addr=0x100; first instr_pc=0x100.
4. Redirect coinciding with response and pop -> popped instr delivered; arriving response dropped; drop_cnt equals remaining outstanding.
5. redirect_pc=2^64-4 -> requests 0xFFFF_FFFF_FFFF_FFFC then 0x0 (wrap).
6. Assert reset mid-DRAIN with 2 outstanding -> all outputs 0 immediately; after release, state BOOT; first request addr=RESET_PC.
